bcd_counter_ctrl: RTL and testbench
===================================

Name: bcd_counter_ctrl

Overview:
Front-end controller for the 3-digit BCD up/down counter chain. It synchronises and debounces the raw Push and Toggle buttons and owns the up/down mode register. It sequences count-enable pulses: one on press, then auto-repeat while the button is held. It optionally saturates at 000/999 using terminal flags returned by the datapath, replacing the ad-hoc edge-clocked mode logic with a single synchronous block on i_Clk.

Parameters:
DEB_CYCLES, 16, consecutive stable samples required before a filtered button level changes (>=2)
REPEAT_DELAY, 64, cycles a press must be held after the first pulse before auto-repeat starts
REPEAT_RATE, 16, cycles between auto-repeat pulses (>=2)
WRAP_EN, 1, 1 = allow 999->000 and 000->999 wrap; 0 = saturate at bounds

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  reset, asynchronous, active-high
i_Push  input  1  raw count button, high = pressed, asynchronous to i_Clk
i_Toggle  input  1  raw mode button, high = pressed, asynchronous to i_Clk
i_Hold  input  1  synchronous; 1 = suppress all count pulses (mode toggling still allowed)
i_AtMax  input  1  datapath value == 999
i_AtMin  input  1  datapath value == 000
o_CntEn  output  1  single-cycle count strobe to the LSD counter
o_UpDn  output  1  0 = up, 1 = down
o_Busy  output  1  high while the push FSM is not IDLE

Behaviour:
- Reset (async, i_Rst=1): o_CntEn=0, o_UpDn=0, o_Busy=0; sync flops, filtered levels and debounce counters=0; all timers=0; FSM=IDLE.
- Sync: each button passes through a 2-flop synchroniser.
- Debounce: a per-button counter increments while the synced value differs from the filtered level and clears when they agree. The filtered level flips when the count reaches DEB_CYCLES-1.
- Press edge = filtered level 0->1, asserted for one cycle.
- Mode: a Toggle press edge inverts o_UpDn on the next clock.
- Push FSM states:
  - IDLE: on Push press edge, emit a candidate pulse and go to DELAY.
  - DELAY: timer counts up to REPEAT_DELAY-1, then emit a candidate pulse, go to REPEAT, and clear the timer. A filtered release goes to IDLE from any state.
  - REPEAT: a candidate pulse every REPEAT_RATE cycles while held.
- o_Busy = (state != IDLE).
- Pulse gating: o_CntEn = candidate & ~i_Hold & ~blocked, where blocked = ~WRAP_EN & ((~o_UpDn & i_AtMax) | (o_UpDn & i_AtMin)).
  - A gated-off pulse is dropped, not deferred.
  - The FSM timers advance regardless of gating.
- Latency: o_CntEn is registered and asserts exactly one cycle after the press edge. The press edge itself occurs 2 + DEB_CYCLES cycles after a clean raw rising edge.
- Simultaneous Toggle press edge and candidate pulse in the same cycle: the pulse uses the pre-toggle o_UpDn, and the toggle takes effect the following cycle.
- o_CntEn is never high on two consecutive cycles.
- Bounce shorter than DEB_CYCLES produces no edge.
- i_Rst asserted mid-hold: immediate return to reset state. After release with the button still held, no pulse until the filtered level has gone 0->1 again. The filter starts at 0, so one pulse occurs after the debounce period.
- Timer widths are $clog2 of the largest parameter; no wrap within a single state.

Decomposition:
- Shared package bcd_ctrl_pkg: FSM state encoding (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2), default timing constants, MODE_UP/MODE_DN constants.
- One sub-module, btn_debounce: synchroniser + debounce counter + filtered level + press-edge output, instantiated twice.
- FSM, mode register and gating stay in the top.

Test Plan:
- Clean Push pulse held 30 cycles (DEB=16, DELAY=64) -> exactly one o_CntEn, 19 cycles after the raw rise; o_UpDn=0; o_Busy high until the filtered release.
- Push held 200 cycles -> pulses at press+1, +64, +80, +96 ... (first + repeats every 16); no pulses after the filtered release.
- Push bounce of 0/1 toggles every 5 cycles for 60 cycles, then low -> zero o_CntEn.
- Toggle press, then Push press -> o_UpDn=1 before the pulse. Coincident Toggle edge and first pulse -> pulse sees o_UpDn=0, which flips the next cycle.
- WRAP_EN=0, i_AtMax=1, up mode, Push held 150 cycles -> no o_CntEn. Switch to down mode -> pulses resume. i_Hold=1 -> no pulses, FSM still cycles.
- i_Rst asserted during REPEAT, released with Push still high -> outputs 0 immediately. The next o_CntEn occurs 2+16+1 cycles after the release, with o_UpDn=0.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD counter front-end controller.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } push_state_e;

  localparam int unsigned DEF_DEB_CYCLES   = 16;
  localparam int unsigned DEF_REPEAT_DELAY = 64;
  localparam int unsigned DEF_REPEAT_RATE  = 16;
  localparam bit          DEF_WRAP_EN      = 1'b1;

  localparam logic MODE_UP = 1'b0;
  localparam logic MODE_DN = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter-based debounce for one raw button;
// emits the filtered level and a one-cycle press pulse on its 0->1 change.
module btn_debounce
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      // Any agreement with the filtered level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Button front end for the 3-digit BCD counter: debounced push with
// auto-repeat, up/down mode register and bound-aware count-enable gating.
module bcd_counter_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter bit          WRAP_EN      = DEF_WRAP_EN
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Push,
  input  logic i_Toggle,
  input  logic i_Hold,
  input  logic i_AtMax,
  input  logic i_AtMin,
  output logic o_CntEn,
  output logic o_UpDn,
  output logic o_Busy
);

  localparam int unsigned TW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE));

  logic          push_level;
  logic          push_press;
  logic          tog_press;
  logic          unused_tog_level;
  push_state_e   state;
  logic [TW-1:0] timer;
  logic          tog_pend;
  logic          candidate_c;
  logic          blocked_c;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_push_deb (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .raw   (i_Push),
    .level (push_level),
    .press (push_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_tog_deb (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .raw   (i_Toggle),
    .level (unused_tog_level),
    .press (tog_press)
  );

  always_comb begin
    candidate_c = 1'b0;
    case (state)
      IDLE:    candidate_c = push_press;
      DELAY:   candidate_c = push_level && (timer == TW'(REPEAT_DELAY - 1));
      REPEAT:  candidate_c = push_level && (timer == TW'(REPEAT_RATE - 1));
      default: candidate_c = 1'b0;
    endcase
  end

  assign blocked_c = ~WRAP_EN & (((o_UpDn == MODE_UP) & i_AtMax) |
                                 ((o_UpDn == MODE_DN) & i_AtMin));

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= IDLE;
      timer    <= '0;
      o_CntEn  <= 1'b0;
      o_UpDn   <= MODE_UP;
      o_Busy   <= 1'b0;
      tog_pend <= 1'b0;
    end else begin
      o_CntEn <= candidate_c & ~i_Hold & ~blocked_c;

      // A toggle landing on a pulse cycle is held back one cycle so the pulse
      // is counted in the old direction.
      if (tog_press && candidate_c) begin
        tog_pend <= 1'b1;
      end else begin
        if (tog_press || tog_pend) o_UpDn <= ~o_UpDn;
        tog_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          timer <= '0;
          if (push_press) begin
            state  <= DELAY;
            o_Busy <= 1'b1;
          end
        end
        DELAY: begin
          if (!push_level) begin
            state  <= IDLE;
            timer  <= '0;
            o_Busy <= 1'b0;
          end else if (timer == TW'(REPEAT_DELAY - 1)) begin
            state <= REPEAT;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REPEAT: begin
          if (!push_level) begin
            state  <= IDLE;
            timer  <= '0;
            o_Busy <= 1'b0;
          end else if (timer == TW'(REPEAT_RATE - 1)) begin
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          timer  <= '0;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed bench for bcd_counter_ctrl: a wrapping instance and a saturating
// instance driven by the same buttons, checked against hand-computed timing.
module tb_bcd_counter_ctrl;

  logic clk = 1'b0;
  logic rst, push, toggle, hold, at_max, at_min;
  logic cnt_en_w, up_dn_w, busy_w;
  logic cnt_en_s, up_dn_s, busy_s;

  int checks   = 0;
  int failures = 0;

  int rel, npulse_w, npulse_s, consec, busy_first, busy_last;
  int pulse_q[$];
  logic prev_w = 1'b0;
  logic prev_s = 1'b0;

  always #5 clk = ~clk;

  bcd_counter_ctrl #(
    .DEB_CYCLES(16), .REPEAT_DELAY(64), .REPEAT_RATE(16), .WRAP_EN(1'b1)
  ) dut_w (
    .i_Clk(clk), .i_Rst(rst), .i_Push(push), .i_Toggle(toggle), .i_Hold(hold),
    .i_AtMax(at_max), .i_AtMin(at_min),
    .o_CntEn(cnt_en_w), .o_UpDn(up_dn_w), .o_Busy(busy_w)
  );

  bcd_counter_ctrl #(
    .DEB_CYCLES(16), .REPEAT_DELAY(64), .REPEAT_RATE(16), .WRAP_EN(1'b0)
  ) dut_s (
    .i_Clk(clk), .i_Rst(rst), .i_Push(push), .i_Toggle(toggle), .i_Hold(hold),
    .i_AtMax(at_max), .i_AtMin(at_min),
    .o_CntEn(cnt_en_s), .o_UpDn(up_dn_s), .o_Busy(busy_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic clear_stats();
    rel = 0; npulse_w = 0; npulse_s = 0; busy_first = -1; busy_last = -1;
    pulse_q.delete();
  endtask

  function automatic int pulse_at(input int idx);
    return (idx < pulse_q.size()) ? pulse_q[idx] : -1;
  endfunction

  // Advance n cycles, sampling outputs on the falling edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rel++;
      if (cnt_en_w) begin
        npulse_w++;
        pulse_q.push_back(rel);
        if (prev_w) consec++;
      end
      if (cnt_en_s) begin
        npulse_s++;
        if (prev_s) consec++;
      end
      prev_w = cnt_en_w;
      prev_s = cnt_en_s;
      if (busy_w) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
    end
  endtask

  task automatic toggle_press();
    toggle = 1'b1; run_cycles(25);
    toggle = 1'b0; run_cycles(40);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; toggle = 1'b0; hold = 1'b0; at_max = 1'b0; at_min = 1'b0;
    consec = 0;
    clear_stats();
    repeat (3) @(negedge clk);
    check_eq("rst_cnt_en", cnt_en_w, 0);
    check_eq("rst_up_dn", up_dn_w, 0);
    check_eq("rst_busy", busy_w, 0);
    check_eq("rst_cnt_en_sat", cnt_en_s, 0);
    rst = 1'b0;
    run_cycles(5);

    // Short clean press: one pulse 20 sample points after the raw rise.
    clear_stats();
    push = 1'b1; run_cycles(30);
    push = 1'b0; run_cycles(60);
    check_eq("short_npulse", npulse_w, 1);
    check_eq("short_first", pulse_at(0), 20);
    check_eq("short_npulse_sat", npulse_s, 1);
    check_eq("short_up_dn", up_dn_w, 0);
    check_eq("short_busy_first", busy_first, 20);
    check_eq("short_busy_last", busy_last, 48);

    // Long hold: first pulse, +64, then every 16 until the filtered release.
    clear_stats();
    push = 1'b1; run_cycles(200);
    push = 1'b0; run_cycles(60);
    check_eq("long_npulse", npulse_w, 10);
    check_eq("long_p0", pulse_at(0), 20);
    check_eq("long_p1", pulse_at(1), 84);
    check_eq("long_p2", pulse_at(2), 100);
    check_eq("long_p9", pulse_at(9), 212);
    check_eq("long_busy_last", busy_last, 218);

    // Bounce of 5-cycle segments never survives the filter.
    clear_stats();
    for (int k = 0; k < 12; k++) begin
      push = (k % 2 == 0);
      run_cycles(5);
    end
    push = 1'b0; run_cycles(60);
    check_eq("bounce_npulse", npulse_w, 0);
    check_eq("bounce_busy", busy_first, -1);

    // Mode toggle before a press.
    clear_stats();
    toggle = 1'b1; run_cycles(25);
    check_eq("tog_up_dn", up_dn_w, 1);
    toggle = 1'b0; run_cycles(40);
    clear_stats();
    push = 1'b1; run_cycles(20);
    check_eq("down_pulse", cnt_en_w, 1);
    check_eq("down_pulse_mode", up_dn_w, 1);
    run_cycles(10);
    push = 1'b0; run_cycles(60);
    toggle_press();
    check_eq("tog_back_up", up_dn_w, 0);

    // Coincident toggle and first pulse: pulse in old mode, flip one cycle later.
    clear_stats();
    push = 1'b1; toggle = 1'b1; run_cycles(20);
    check_eq("coin_pulse", cnt_en_w, 1);
    check_eq("coin_mode_at_pulse", up_dn_w, 0);
    run_cycles(1);
    check_eq("coin_mode_after", up_dn_w, 1);
    check_eq("coin_pulse_after", cnt_en_w, 0);
    run_cycles(9);
    push = 1'b0; toggle = 1'b0; run_cycles(60);

    // Saturation at max in up mode.
    toggle_press();
    check_eq("sat_up_mode", up_dn_w, 0);
    at_max = 1'b1;
    clear_stats();
    push = 1'b1; run_cycles(150);
    push = 1'b0; run_cycles(60);
    check_eq("sat_max_npulse", npulse_s, 0);
    check_eq("wrap_max_npulse", npulse_w, 7);
    toggle_press();
    clear_stats();
    push = 1'b1; run_cycles(30);
    push = 1'b0; run_cycles(60);
    check_eq("sat_down_resume", npulse_s, 1);
    at_max = 1'b0; at_min = 1'b1;
    clear_stats();
    push = 1'b1; run_cycles(30);
    push = 1'b0; run_cycles(60);
    check_eq("sat_min_npulse", npulse_s, 0);
    check_eq("wrap_min_npulse", npulse_w, 1);
    at_min = 1'b0;

    // Hold suppresses pulses while the FSM keeps sequencing.
    hold = 1'b1;
    clear_stats();
    push = 1'b1; run_cycles(100);
    check_eq("hold_busy", busy_w, 1);
    push = 1'b0; run_cycles(60);
    check_eq("hold_npulse", npulse_w, 0);
    check_eq("hold_npulse_sat", npulse_s, 0);
    check_eq("hold_busy_first", busy_first, 20);
    hold = 1'b0;

    // Reset in REPEAT with the button still held.
    clear_stats();
    push = 1'b1; run_cycles(120);
    check_eq("pre_rst_mode", up_dn_w, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_cnt_en", cnt_en_w, 0);
    check_eq("mid_rst_up_dn", up_dn_w, 0);
    check_eq("mid_rst_busy", busy_w, 0);
    run_cycles(3);
    rst = 1'b0;
    clear_stats();
    run_cycles(30);
    check_eq("post_rst_npulse", npulse_w, 1);
    check_eq("post_rst_first", pulse_at(0), 20);
    check_eq("post_rst_mode", up_dn_w, 0);
    push = 1'b0; run_cycles(60);

    check_eq("no_back_to_back", consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
